// File: rtl/soc_system_sysid_pkg.sv
// Shared word offsets, CTRL bit positions and the bus word type for the sysid register bank.
package soc_system_sysid_pkg;

  localparam int ADDR_ID       = 0;
  localparam int ADDR_TS       = 1;
  localparam int ADDR_UP_LO    = 2;
  localparam int ADDR_UP_HI    = 3;
  localparam int ADDR_CTRL     = 4;
  localparam int ADDR_SCRATCH0 = 8;

  localparam int CTRL_CLR = 0;
  localparam int CTRL_HB  = 1;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/soc_system_sysid_uptime.sv
// 64-bit free-running uptime counter; a low-word read (snap) captures the high word so
// software can assemble a consistent 64-bit value from two reads.
module soc_system_sysid_uptime
  import soc_system_sysid_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  logic  clr,
  input  logic  snap,
  output word_t lo,
  output word_t hi_shadow
);

  logic [63:0] count;

  // Clear beats both the increment and a coincident snap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      hi_shadow <= '0;
    end else if (clr) begin
      count     <= '0;
      hi_shadow <= '0;
    end else begin
      count <= count + 64'd1;
      if (snap) begin
        hi_shadow <= count[63:32];
      end
    end
  end

  assign lo = count[31:0];

endmodule

// File: rtl/soc_system_sysid_regs.sv
// Avalon-MM sysid register bank: ID, timestamp, uptime, CTRL and byte-writable scratch words.
// Optional LED heartbeat prescaler is compiled in with SOC_SYSID_HEARTBEAT_EN.
module soc_system_sysid_regs
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE      = 32'h594D8E9B,
  parameter logic [31:0] TIMESTAMP     = 32'h00000000,
  parameter int          NUM_SCRATCH   = 4,
  parameter int          ADDR_W        = 4,
  parameter int          HEARTBEAT_DIV = 50000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              heartbeat
);

  if (NUM_SCRATCH < 1 || NUM_SCRATCH > 8 || (ADDR_SCRATCH0 + NUM_SCRATCH) > (1 << ADDR_W) ||
      HEARTBEAT_DIV < 1) begin : g_param_check
    $error("soc_system_sysid_regs: illegal parameter combination");
  end

  int    addr_int;
  int    scr_idx;
  logic  scr_hit;
  logic  clr;
  logic  snap;
  word_t up_lo;
  word_t up_hi;
  word_t rd_mux;
  word_t scratch [NUM_SCRATCH];

  assign addr_int = int'(address);
  assign scr_idx  = addr_int - ADDR_SCRATCH0;
  assign scr_hit  = (addr_int >= ADDR_SCRATCH0) && (addr_int < ADDR_SCRATCH0 + NUM_SCRATCH);
  assign clr      = write && (addr_int == ADDR_CTRL) && byteenable[0] && writedata[CTRL_CLR];
  assign snap     = read && (addr_int == ADDR_UP_LO);

  soc_system_sysid_uptime u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (clr),
    .snap      (snap),
    .lo        (up_lo),
    .hi_shadow (up_hi)
  );

`ifdef SOC_SYSID_HEARTBEAT_EN
  logic [31:0] presc;
  logic        hb;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      hb    <= 1'b0;
    end else if (clr) begin
      presc <= '0;
      hb    <= 1'b0;
    end else if (presc == 32'(HEARTBEAT_DIV - 1)) begin
      presc <= '0;
      hb    <= ~hb;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  assign heartbeat = hb;
`else
  assign heartbeat = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch[i] <= '0;
      end
    end else if (write && scr_hit) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (scr_idx == i) begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
              scratch[i][8*b +: 8] <= writedata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Mux sees pre-edge state, so a same-cycle write or clear is not visible to the read.
  always_comb begin
    rd_mux = '0;
    case (addr_int)
      ADDR_ID:    rd_mux = ID_VALUE;
      ADDR_TS:    rd_mux = TIMESTAMP;
      ADDR_UP_LO: rd_mux = up_lo;
      ADDR_UP_HI: rd_mux = up_hi;
      ADDR_CTRL:  rd_mux[CTRL_HB] = heartbeat;
      default:    rd_mux = '0;
    endcase
    if (scr_hit) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (scr_idx == i) begin
          rd_mux = scratch[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_regs.sv
// Directed self-checking bench for soc_system_sysid_regs; heartbeat checks follow SOC_SYSID_HEARTBEAT_EN.
module tb_soc_system_sysid_regs;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        heartbeat;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ID = 32'h594D8E9B;

  soc_system_sysid_regs #(
    .ID_VALUE      (ID),
    .TIMESTAMP     (32'h00000000),
    .NUM_SCRATCH   (4),
    .ADDR_W        (4),
    .HEARTBEAT_DIV (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .heartbeat     (heartbeat)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [3:0] a, input string tag, input logic [31:0] exp);
    @(negedge clock);
    address = a;
    read    = 1'b1;
    @(negedge clock);
    read = 1'b0;
    check_eq({tag, "_vld"}, {31'b0, readdatavalid}, 32'd1);
    check_eq(tag, readdata, exp);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  initial begin
    logic [3:0]  b2b_addr [3];
    logic [31:0] lo_val;

    reset_n    = 1'b0;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_rdata", readdata, 32'd0);
    check_eq("rst_vld", {31'b0, readdatavalid}, 32'd0);
    check_eq("rst_hb", {31'b0, heartbeat}, 32'd0);
    reset_n = 1'b1;

    // Latency: valid exactly one cycle after the accepted read, data held afterwards.
    @(negedge clock);
    address = 4'd0;
    read    = 1'b1;
    check_eq("lat_pre_vld", {31'b0, readdatavalid}, 32'd0);
    @(negedge clock);
    read = 1'b0;
    check_eq("id_vld", {31'b0, readdatavalid}, 32'd1);
    check_eq("id", readdata, ID);
    @(negedge clock);
    check_eq("id_vld_drop", {31'b0, readdatavalid}, 32'd0);
    check_eq("id_hold", readdata, ID);
    do_read(4'd1, "ts", 32'h00000000);

    do_read(4'd8, "scr0_init", 32'd0);
    do_write(4'd8, 32'hDEADBEEF, 4'b0101);
    do_read(4'd8, "scr0_be0101", 32'h00AD00EF);
    do_write(4'd8, 32'h12345678, 4'b1010);
    do_read(4'd8, "scr0_be1010", 32'h12AD56EF);
    do_write(4'd0, 32'h11111111, 4'b1111);
    do_read(4'd0, "id_ro", ID);
    do_write(4'd11, 32'hFFFFFFFF, 4'b1111);
    do_read(4'd11, "scr3", 32'hFFFFFFFF);
    do_read(4'd8, "scr0_keep", 32'h12AD56EF);
    do_write(4'd12, 32'hCAFEF00D, 4'b1111);
    do_read(4'd12, "unmapped", 32'd0);

    // Same-cycle read and write of a scratch word returns the old value.
    @(negedge clock);
    address    = 4'd9;
    writedata  = 32'hA5A5A5A5;
    byteenable = 4'b1111;
    read       = 1'b1;
    write      = 1'b1;
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    check_eq("rw_same_old", readdata, 32'd0);
    do_read(4'd9, "rw_same_new", 32'hA5A5A5A5);

    // Uptime snapshot across a low-word carry.
    @(negedge clock);
    force dut.u_uptime.count = 64'h0000_0001_FFFF_FFFF;
    address = 4'd2;
    read    = 1'b1;
    #1;
    release dut.u_uptime.count;
    @(negedge clock);
    read = 1'b0;
    check_eq("up_lo_snap", readdata, 32'hFFFFFFFF);
    repeat (2) @(negedge clock);
    do_read(4'd3, "up_hi_snap", 32'h00000001);

    // CTRL clear, then low word restarts near zero and high shadow is cleared.
    do_write(4'd4, 32'h00000001, 4'b0001);
    @(negedge clock);
    address = 4'd2;
    read    = 1'b1;
    @(negedge clock);
    read   = 1'b0;
    lo_val = readdata;
    check_eq("clr_lo_small", {31'b0, (lo_val < 32'd5)}, 32'd1);
    do_read(4'd3, "clr_hi", 32'd0);
    @(negedge clock);
    address = 4'd4;
    read    = 1'b1;
    @(negedge clock);
    read = 1'b0;
    check_eq("ctrl_bit0", readdata & 32'h1, 32'd0);
`ifndef SOC_SYSID_HEARTBEAT_EN
    check_eq("ctrl_full", readdata, 32'd0);
    check_eq("hb_off", {31'b0, heartbeat}, 32'd0);
`endif

    // Back-to-back reads of reserved / unmapped words.
    b2b_addr[0] = 4'd5;
    b2b_addr[1] = 4'd12;
    b2b_addr[2] = 4'd15;
    @(negedge clock);
    read       = 1'b1;
    address    = b2b_addr[0];
    readdata_seed: begin end
    for (int i = 1; i < 3; i++) begin
      @(negedge clock);
      check_eq($sformatf("b2b_vld%0d", i - 1), {31'b0, readdatavalid}, 32'd1);
      check_eq($sformatf("b2b_dat%0d", i - 1), readdata, 32'd0);
      address = b2b_addr[i];
    end
    @(negedge clock);
    read = 1'b0;
    check_eq("b2b_vld2", {31'b0, readdatavalid}, 32'd1);
    check_eq("b2b_dat2", readdata, 32'd0);
    @(negedge clock);
    check_eq("b2b_vld_end", {31'b0, readdatavalid}, 32'd0);

`ifdef SOC_SYSID_HEARTBEAT_EN
    // Sync prescaler with a clear, then poll CTRL every cycle.
    do_write(4'd4, 32'h00000001, 4'b0001);
    address = 4'd4;
    read    = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(negedge clock);
        check_eq($sformatf("ctrl_hb%0d", k), readdata & 32'h2,
                 ((((k - 1) / 4) % 2) != 0) ? 32'h2 : 32'h0);
      end
      check_eq($sformatf("hb%0d", k), {31'b0, heartbeat}, 32'((k / 4) % 2));
    end
`else
    @(negedge clock);
    address = 4'd0;
    read    = 1'b1;
    @(negedge clock);
    check_eq("mid_pre_vld", {31'b0, readdatavalid}, 32'd1);
`endif

    // Reset mid-stream: outputs drop without waiting for a clock.
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", {31'b0, readdatavalid}, 32'd0);
    check_eq("mid_rst_hb", {31'b0, heartbeat}, 32'd0);
    check_eq("mid_rst_rdata", readdata, 32'd0);
    read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    do_read(4'd8, "post_rst_scr0", 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
